// File: rtl/hist_eq_bank_scheduler.sv
// N-bank frame scheduler for histogram equalisation: the CDF-build stage runs up to NUM_BANKS-1 frames ahead of the remap stage.
// Optional HIST_EQ_FRAME_CNT_EN adds the frame_count and overrun ports.
module hist_eq_bank_scheduler #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter int CDF_W     = 20,
    parameter int PIXELS    = 307200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              input_start,
    input  logic              input_done,
    output logic              output_start,
    input  logic              output_done,
    input  logic              cdf_valid,
    input  logic [CDF_W-1:0]  cdf_min,
    output logic [BANK_W-1:0] input_bank,
    output logic [BANK_W-1:0] output_bank,
    output logic [CDF_W-1:0]  cdf_min_out,
    output logic [CDF_W-1:0]  divisor,
    output logic              busy
`ifdef HIST_EQ_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_count,
    output logic              overrun
`endif
);

    localparam int FILL_W = $clog2(NUM_BANKS + 1);
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(NUM_BANKS);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [CDF_W-1:0]  PIXELS_C  = CDF_W'(PIXELS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [FILL_W-1:0] fill_count_reg, fill_count_next;
    logic [BANK_W-1:0] input_bank_reg, input_bank_next;
    logic [BANK_W-1:0] output_bank_reg, output_bank_next;
    logic              input_start_reg, input_start_next;
    logic              output_start_reg, output_start_next;
    logic              stop_pending_reg, stop_pending_next;
    logic [CDF_W-1:0]  cdf_reg [NUM_BANKS];
    logic [CDF_W-1:0]  diff;
    logic              in_fire, out_fire;

    // Completion pulses only count while the matching stage is actually running.
    assign in_fire  = input_done & input_start_reg;
    assign out_fire = output_done & output_start_reg;

    always_comb begin
        state_next        = state_reg;
        stop_pending_next = stop_pending_reg;
        fill_count_next   = fill_count_reg;
        input_bank_next   = input_bank_reg;
        output_bank_next  = output_bank_reg;

        if (in_fire && !out_fire)
            fill_count_next = fill_count_reg + 1'b1;
        else if (out_fire && !in_fire)
            fill_count_next = fill_count_reg - 1'b1;
        if (in_fire)
            input_bank_next = (input_bank_reg == LAST_BANK) ? '0 : input_bank_reg + 1'b1;
        if (out_fire)
            output_bank_next = (output_bank_reg == LAST_BANK) ? '0 : output_bank_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                stop_pending_next = 1'b0;
                if (start)
                    state_next = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next        = DRAIN;
                    stop_pending_next = input_start_reg && !in_fire;
                end
            end
            DRAIN: begin
                if (in_fire)
                    stop_pending_next = 1'b0;
                if (fill_count_reg == '0 && !input_start_reg && !stop_pending_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Both strobes drop for at least one cycle after their done pulse.
        if (input_start_reg)
            input_start_next = !in_fire;
        else
            input_start_next = (state_reg == RUN) && !stop && (fill_count_next < FULL);

        if (output_start_reg)
            output_start_next = !out_fire;
        else
            output_start_next = (state_reg != IDLE) && (fill_count_next != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            stop_pending_reg <= 1'b0;
            fill_count_reg   <= '0;
            input_bank_reg   <= '0;
            output_bank_reg  <= '0;
            input_start_reg  <= 1'b0;
            output_start_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            stop_pending_reg <= stop_pending_next;
            fill_count_reg   <= fill_count_next;
            input_bank_reg   <= input_bank_next;
            output_bank_reg  <= output_bank_next;
            input_start_reg  <= input_start_next;
            output_start_reg <= output_start_next;
        end
    end

    // A cdf_valid coincident with input_done still lands in the pre-increment bank.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_cdf
            always_ff @(posedge clock) begin
                if (reset)
                    cdf_reg[gi] <= '0;
                else if (cdf_valid && input_start_reg && input_bank_reg == BANK_W'(gi))
                    cdf_reg[gi] <= cdf_min;
            end
        end
    endgenerate

    assign cdf_min_out  = cdf_reg[output_bank_reg];
    assign diff         = PIXELS_C - cdf_min_out;
    assign divisor      = (cdf_min_out >= PIXELS_C || diff == '0) ? CDF_W'(1) : diff;
    assign input_start  = input_start_reg;
    assign output_start = output_start_reg;
    assign input_bank   = input_bank_reg;
    assign output_bank  = output_bank_reg;
    assign busy         = (state_reg != IDLE);

`ifdef HIST_EQ_FRAME_CNT_EN
    logic [15:0] frame_count_reg;
    logic        overrun_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_reg <= '0;
            overrun_reg     <= 1'b0;
        end else begin
            if (out_fire)
                frame_count_reg <= frame_count_reg + 16'd1;
            overrun_reg <= ((start && state_reg == IDLE) ? 1'b0 : overrun_reg)
                           | (cdf_valid & ~input_start_reg);
        end
    end

    assign frame_count = frame_count_reg;
    assign overrun     = overrun_reg;
`endif

endmodule

// File: tb/tb_hist_eq_bank_scheduler.sv
// Directed bench: instance a (2 banks) covers handshakes, divisor edge cases and stop/drain; instance b (4 banks) covers full, wrap and reset.
module tb_hist_eq_bank_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_stop, a_idone, a_odone, a_cv;
    logic [19:0] a_cmin;
    logic        a_is, a_os, a_busy;
    logic [0:0]  a_ib, a_ob;
    logic [19:0] a_cmo, a_div;

    logic        b_start, b_stop, b_idone, b_odone, b_cv;
    logic [19:0] b_cmin;
    logic        b_is, b_os, b_busy;
    logic [1:0]  b_ib, b_ob;
    logic [19:0] b_cmo, b_div;
`ifdef HIST_EQ_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
    logic        a_ovr, b_ovr;
`endif

    int total  = 0;
    int passed = 0;
    int failed = 0;

    hist_eq_bank_scheduler #(.NUM_BANKS(2), .BANK_W(1)) u_a (
        .clock(clk), .reset(rst), .start(a_start), .stop(a_stop),
        .input_start(a_is), .input_done(a_idone), .output_start(a_os),
        .output_done(a_odone), .cdf_valid(a_cv), .cdf_min(a_cmin),
        .input_bank(a_ib), .output_bank(a_ob), .cdf_min_out(a_cmo),
        .divisor(a_div), .busy(a_busy)
`ifdef HIST_EQ_FRAME_CNT_EN
        , .frame_count(a_fc), .overrun(a_ovr)
`endif
    );

    hist_eq_bank_scheduler #(.NUM_BANKS(4), .BANK_W(2)) u_b (
        .clock(clk), .reset(rst), .start(b_start), .stop(b_stop),
        .input_start(b_is), .input_done(b_idone), .output_start(b_os),
        .output_done(b_odone), .cdf_valid(b_cv), .cdf_min(b_cmin),
        .input_bank(b_ib), .output_bank(b_ob), .cdf_min_out(b_cmo),
        .divisor(b_div), .busy(b_busy)
`ifdef HIST_EQ_FRAME_CNT_EN
        , .frame_count(b_fc), .overrun(b_ovr)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
            $display("check %s obs=%0d exp=%0d ok", tag, obs, exp);
        end else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {a_start, a_stop, a_idone, a_odone, a_cv} = '0;
        {b_start, b_stop, b_idone, b_odone, b_cv} = '0;
        a_cmin = '0;
        b_cmin = '0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("a_rst_is", 32'(a_is), 0);
        check("a_rst_os", 32'(a_os), 0);
        check("a_rst_busy", 32'(a_busy), 0);
        check("a_rst_ob", 32'(a_ob), 0);
        check("a_rst_cmo", 32'(a_cmo), 0);
        check("a_rst_div", 32'(a_div), 307200);

        // input_done while idle is ignored; stray cdf_valid flags overrun
        a_idone = 1'b1; a_cv = 1'b1; a_cmin = 20'd55; tick();
        a_idone = 1'b0; a_cv = 1'b0;
        check("a_stray_idone_ib", 32'(a_ib), 0);
        check("a_stray_cv_cmo", 32'(a_cmo), 0);
`ifdef HIST_EQ_FRAME_CNT_EN
        check("a_overrun_set", 32'(a_ovr), 1);
`endif

        // start, first frame into bank 0 with cdf_min=1200
        a_start = 1'b1; b_start = 1'b1; tick();
        a_start = 1'b0; b_start = 1'b0;
        check("a_busy_run", 32'(a_busy), 1);
`ifdef HIST_EQ_FRAME_CNT_EN
        check("a_overrun_clr", 32'(a_ovr), 0);
`endif
        tick();
        check("a_is_first", 32'(a_is), 1);
        check("a_ib_first", 32'(a_ib), 0);
        a_cv = 1'b1; a_cmin = 20'd1200; tick();
        a_cv = 1'b0;
        a_idone = 1'b1; tick();
        a_idone = 1'b0;
        check("a_os_after_done", 32'(a_os), 1);
        check("a_ob_after_done", 32'(a_ob), 0);
        check("a_cmo_1200", 32'(a_cmo), 1200);
        check("a_div_1200", 32'(a_div), 306000);
        check("a_is_gap", 32'(a_is), 0);
        tick();
        check("a_is_bank1", 32'(a_is), 1);
        check("a_ib_bank1", 32'(a_ib), 1);

        // bank1 cdf_min = PIXELS -> divisor 1; pipeline becomes full
        a_cv = 1'b1; a_cmin = 20'd307200; tick();
        a_cv = 1'b0;
        a_idone = 1'b1; tick();
        a_idone = 1'b0;
        tick();
        check("a_full_is_low", 32'(a_is), 0);
        a_odone = 1'b1; tick();
        a_odone = 1'b0;
        check("a_ob_adv", 32'(a_ob), 1);
        check("a_cmo_pix", 32'(a_cmo), 307200);
        check("a_div_pix", 32'(a_div), 1);
        check("a_is_after_odone", 32'(a_is), 1);
        check("a_os_gap", 32'(a_os), 0);
        tick();

        // bank0 cdf_min = 0 -> divisor PIXELS
        a_cv = 1'b1; a_cmin = 20'd0; tick();
        a_cv = 1'b0;
        a_idone = 1'b1; tick();
        a_idone = 1'b0;
        a_odone = 1'b1; tick();
        a_odone = 1'b0;
        check("a_ob_wrap", 32'(a_ob), 0);
        check("a_div_zero", 32'(a_div), 307200);
        tick();

        // stop mid-frame: current frame finishes, nothing new starts, then drain
        a_stop = 1'b1; tick();
        a_stop = 1'b0;
        check("a_stop_busy", 32'(a_busy), 1);
        check("a_stop_is_held", 32'(a_is), 1);
        a_idone = 1'b1; tick();
        a_idone = 1'b0;
        tick();
        check("a_drain_no_is", 32'(a_is), 0);
        a_odone = 1'b1; tick();
        a_odone = 1'b0;
        tick();
        a_odone = 1'b1; tick();
        a_odone = 1'b0;
        tick(); tick();
        check("a_idle_busy", 32'(a_busy), 0);
        check("a_idle_os", 32'(a_os), 0);
        check("a_idle_ob", 32'(a_ob), 0);
        check("a_idle_ib", 32'(a_ib), 0);
`ifdef HIST_EQ_FRAME_CNT_EN
        check("a_frame_count", 32'(a_fc), 4);
`endif

        // instance b (4 banks), started together with a; fill all four banks
        for (int k = 0; k < 4; k++) begin
            b_idone = 1'b1; tick();
            b_idone = 1'b0;
            check($sformatf("b_ib_fill%0d", k), 32'(b_ib), 32'((k + 1) % 4));
            tick();
        end
        tick();
        check("b_full_is", 32'(b_is), 0);
        check("b_full_os", 32'(b_os), 1);
        b_odone = 1'b1; tick();
        b_odone = 1'b0;
        check("b_unfull_is", 32'(b_is), 1);
        check("b_unfull_ob", 32'(b_ob), 1);
        tick();
        b_odone = 1'b1; tick();
        b_odone = 1'b0;
        tick();

        // simultaneous done pulses with two frames queued
        b_idone = 1'b1; b_odone = 1'b1; tick();
        b_idone = 1'b0; b_odone = 1'b0;
        check("b_sim1_ib", 32'(b_ib), 1);
        check("b_sim1_ob", 32'(b_ob), 3);
        tick();
        b_idone = 1'b1; b_odone = 1'b1; tick();
        b_idone = 1'b0; b_odone = 1'b0;
        check("b_sim2_ib", 32'(b_ib), 2);
        check("b_sim2_ob_wrap", 32'(b_ob), 0);
        tick();

        // exactly two frames remain queued
        b_odone = 1'b1; tick();
        b_odone = 1'b0;
        tick();
        check("b_one_left_os", 32'(b_os), 1);
        b_odone = 1'b1; tick();
        b_odone = 1'b0;
        tick();
        check("b_empty_os", 32'(b_os), 0);
        b_odone = 1'b1; tick();
        b_odone = 1'b0;
        check("b_stray_odone_ob", 32'(b_ob), 2);
`ifdef HIST_EQ_FRAME_CNT_EN
        check("b_frame_count", 32'(b_fc), 6);
`endif

        // reset mid-RUN
        check("b_busy_pre_rst", 32'(b_busy), 1);
        rst = 1'b1; tick();
        check("b_rst_is", 32'(b_is), 0);
        check("b_rst_os", 32'(b_os), 0);
        check("b_rst_ib", 32'(b_ib), 0);
        check("b_rst_ob", 32'(b_ob), 0);
        check("b_rst_busy", 32'(b_busy), 0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
